// File: rtl/muldiv_pkg.sv
// Shared constants and types for the HI/LO multiply/divide controller.
// Covers funct decode values, pipe control encodings, FSM states and engine ops.
package muldiv_pkg;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [2:0] PIPE_FREE  = 3'b101;
    localparam logic [2:0] PIPE_STALL = 3'b000;

    localparam logic [5:0] STEP_LAST = 6'd31;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Encoding matches funct[1:0] of the start-class instructions.
    typedef enum logic [1:0] {MUL_S, MUL_U, DIV_S, DIV_U} op_e;

    function automatic logic op_is_div(input op_e op);
        return (op == DIV_S) || (op == DIV_U);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: radix-2 shift-add multiply and restoring divide.
// {hi,lo} is the 64-bit working register; b holds the multiplicand/divisor.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  op_e          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] hi_raw,
    output logic [W-1:0] lo_raw
);

    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;
    logic [W-1:0] r_b;
    logic         r_div;

    logic [W:0]   w_add;
    logic [W:0]   w_shl;
    logic         w_fits;
    logic [W-1:0] w_sub;
    logic [W-1:0] w_hi_next;
    logic [W-1:0] w_lo_next;

    always_comb begin
        w_add  = {1'b0, r_hi} + {1'b0, r_b};
        // Partial remainder can reach W+1 bits after the shift.
        w_shl  = {r_hi, r_lo[W-1]};
        w_fits = (w_shl >= {1'b0, r_b});
        w_sub  = w_shl[W-1:0] - r_b;
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        if (r_div) begin
            if (w_fits) begin
                w_hi_next = w_sub;
                w_lo_next = {r_lo[W-2:0], 1'b1};
            end else begin
                w_hi_next = w_shl[W-1:0];
                w_lo_next = {r_lo[W-2:0], 1'b0};
            end
        end else if (r_lo[0]) begin
            w_hi_next = w_add[W:1];
            w_lo_next = {w_add[0], r_lo[W-1:1]};
        end else begin
            w_hi_next = {1'b0, r_hi[W-1:1]};
            w_lo_next = {r_hi[0], r_lo[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
        end else if (load) begin
            r_hi  <= '0;
            r_lo  <= a;
            r_b   <= b;
            r_div <= op_is_div(op);
        end else if (step) begin
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
        end
    end

    assign hi_raw = r_hi;
    assign lo_raw = r_lo;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO-class instruction decode, operation sequencing, sign fix-up and HI/LO ownership.
// Only HI/LO hazards stall the fetch path; unrelated instructions issue during an operation.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic [2:0]      pipe_ctrl,
    output logic            busy,
    output logic [XLEN-1:0] hilo_rdata,
    output logic            hilo_rvalid
);

    state_e          r_state;
    state_e          w_state_next;
    logic [5:0]      r_cnt;
    op_e             r_op;
    logic            r_neg_lo;
    logic            r_neg_hi;
    logic            r_divz;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    logic            w_rtype;
    logic [5:0]      w_funct;
    logic            w_start;
    logic            w_mf_hi;
    logic            w_mf_lo;
    logic            w_mt_hi;
    logic            w_mt_lo;
    logic            w_access;
    op_e             w_op;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_divz;
    logic            w_accept;
    logic [XLEN-1:0] w_hi_raw;
    logic [XLEN-1:0] w_lo_raw;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_res_hi;
    logic [XLEN-1:0] w_res_lo;
    logic            w_unused_instr;

    assign w_unused_instr = ^instr[25:6];

    assign w_rtype  = (instr[31:26] == 6'd0);
    assign w_funct  = instr[5:0];
    assign w_start  = w_rtype && (w_funct[5:2] == F_MULT[5:2]);
    assign w_mf_hi  = w_rtype && (w_funct == F_MFHI);
    assign w_mf_lo  = w_rtype && (w_funct == F_MFLO);
    assign w_mt_hi  = w_rtype && (w_funct == F_MTHI);
    assign w_mt_lo  = w_rtype && (w_funct == F_MTLO);
    assign w_access = w_mf_hi | w_mf_lo | w_mt_hi | w_mt_lo;

    // Signed variants have funct[0]=0; the engine only ever sees magnitudes.
    assign w_op     = op_e'(w_funct[1:0]);
    assign w_a_neg  = ~w_funct[0] & rs_data[XLEN-1];
    assign w_b_neg  = ~w_funct[0] & rt_data[XLEN-1];
    assign w_a_mag  = w_a_neg ? -rs_data : rs_data;
    assign w_b_mag  = w_b_neg ? -rt_data : rt_data;
    assign w_divz   = w_funct[1] && (rt_data == '0);
    assign w_accept = w_start && (r_state == IDLE);

    assign busy        = (r_state != IDLE);
    assign pipe_ctrl   = ((w_start || w_access) && busy) ? PIPE_STALL : PIPE_FREE;
    assign hilo_rvalid = rst && !busy && (w_mf_hi || w_mf_lo);
    assign hilo_rdata  = !hilo_rvalid ? '0 : (w_mf_hi ? r_hi : r_lo);

    muldiv_core #(.W(XLEN)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (w_accept),
        .step   (r_state == RUN),
        .op     (w_op),
        .a      (w_a_mag),
        .b      (w_b_mag),
        .hi_raw (w_hi_raw),
        .lo_raw (w_lo_raw)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = w_divz ? DONE : RUN;
            RUN:  if (r_cnt == STEP_LAST) w_state_next = DONE;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op     <= MUL_S;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_divz   <= 1'b0;
            r_op_a   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cnt    <= '0;
                r_op     <= w_op;
                r_neg_lo <= w_a_neg ^ w_b_neg;
                r_neg_hi <= w_a_neg;
                r_divz   <= w_divz;
                r_op_a   <= rs_data;
            end else if ((r_state == RUN) && (r_cnt != STEP_LAST)) begin
                r_cnt <= r_cnt + 6'd1;
            end
        end
    end

    always_comb begin
        w_prod   = {w_hi_raw, w_lo_raw};
        w_res_hi = '0;
        w_res_lo = '0;
        if (r_divz) begin
            w_res_hi = r_op_a;
            w_res_lo = '1;
        end else if (op_is_div(r_op)) begin
            w_res_hi = r_neg_hi ? -w_hi_raw : w_hi_raw;
            w_res_lo = r_neg_lo ? -w_lo_raw : w_lo_raw;
        end else begin
            if (r_neg_lo) w_prod = -w_prod;
            w_res_hi = w_prod[2*XLEN-1:XLEN];
            w_res_lo = w_prod[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == DONE) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (!busy) begin
            if (w_mt_hi) r_hi <= rs_data;
            if (w_mt_lo) r_lo <= rs_data;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: MF results go through a scoreboard queue,
// stall/busy timing is checked cycle by cycle against the documented schedule.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [2:0]  pipe_ctrl;
    logic        busy;
    logic [31:0] hilo_rdata;
    logic        hilo_rvalid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    localparam logic [31:0] NOP = 32'h2000_0000;

    always #5 clk = ~clk;

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .pipe_ctrl   (pipe_ctrl),
        .busy        (busy),
        .hilo_rdata  (hilo_rdata),
        .hilo_rvalid (hilo_rvalid)
    );

    function automatic logic [31:0] rtype(input logic [5:0] f);
        return {26'd0, f};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input string tag, input logic [5:0] f,
                            input logic [31:0] a, input logic [31:0] b);
        cyc();
        instr = rtype(f); rs_data = a; rt_data = b;
        @(negedge clk);
        check({tag, " accept busy"}, {31'd0, busy}, 32'd0);
        check({tag, " accept pipe"}, {29'd0, pipe_ctrl}, {29'd0, PIPE_FREE});
        $display("start %s rs=%h rt=%h", tag, a, b);
    endtask

    task automatic wait_idle(input string tag, input int n);
        int  k = 0;
        bit  done = 1'b0;
        while (!done && k < 100) begin
            cyc();
            instr = NOP;
            @(negedge clk);
            if (!busy) done = 1'b1;
            else begin
                k++;
                check({tag, " nop issues"}, {29'd0, pipe_ctrl}, {29'd0, PIPE_FREE});
            end
        end
        check({tag, " busy cycles"}, k, n);
        $display("idle %s after %0d busy cycles", tag, k);
    endtask

    task automatic issue_mf(input string tag, input bit is_hi,
                            input logic [31:0] exp, input int n_stall);
        int   k = 0;
        exp_t e;
        sb_q.push_back('{tag, exp});
        cyc();
        instr = rtype(is_hi ? F_MFHI : F_MFLO); rs_data = '0; rt_data = '0;
        @(negedge clk);
        while (!hilo_rvalid && k < 100) begin
            check({tag, " stall pipe"}, {29'd0, pipe_ctrl}, {29'd0, PIPE_STALL});
            k++;
            cyc();
            @(negedge clk);
        end
        check({tag, " rvalid"}, {31'd0, hilo_rvalid}, 32'd1);
        if (hilo_rvalid) begin
            e = sb_q.pop_front();
            check({e.tag, " pipe"}, {29'd0, pipe_ctrl}, {29'd0, PIPE_FREE});
            check({e.tag, " data"}, hilo_rdata, e.data);
        end
        check({tag, " stall cycles"}, k, n_stall);
        $display("%s %s data=%h stalls=%0d", is_hi ? "MFHI" : "MFLO", tag, hilo_rdata, k);
    endtask

    // Presents an instruction and holds it until the controller lets it issue.
    task automatic issue_hold(input string tag, input logic [31:0] word,
                              input logic [31:0] a, input logic [31:0] b, input int n_stall);
        int k = 0;
        cyc();
        instr = word; rs_data = a; rt_data = b;
        @(negedge clk);
        while (pipe_ctrl != PIPE_FREE && k < 100) begin
            check({tag, " stall pipe"}, {29'd0, pipe_ctrl}, {29'd0, PIPE_STALL});
            k++;
            cyc();
            @(negedge clk);
        end
        check({tag, " stall cycles"}, k, n_stall);
        check({tag, " issue busy"}, {31'd0, busy}, 32'd0);
        $display("issue %s rs=%h stalls=%0d", tag, a, k);
    endtask

    initial begin
        instr = rtype(F_MFHI); rs_data = '0; rt_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset pipe", {29'd0, pipe_ctrl}, {29'd0, PIPE_FREE});
        check("reset rvalid", {31'd0, hilo_rvalid}, 32'd0);
        check("reset rdata", hilo_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        instr = NOP;

        start_op("MULT", F_MULT, 32'd7, 32'hFFFF_FFFD);
        wait_idle("MULT", 33);
        issue_mf("MULT hi", 1'b1, 32'hFFFF_FFFF, 0);
        issue_mf("MULT lo", 1'b0, 32'hFFFF_FFEB, 0);

        start_op("MULTU", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue_mf("MULTU lo", 1'b0, 32'h0000_0001, 33);
        issue_mf("MULTU hi", 1'b1, 32'hFFFF_FFFE, 0);

        start_op("MULT min", F_MULT, 32'h8000_0000, 32'h8000_0000);
        issue_mf("MULT min hi", 1'b1, 32'h4000_0000, 33);
        issue_mf("MULT min lo", 1'b0, 32'h0000_0000, 0);

        start_op("DIV", F_DIV, 32'hFFFF_FFF9, 32'd2);
        issue_mf("DIV lo", 1'b0, 32'hFFFF_FFFD, 33);
        issue_mf("DIV hi", 1'b1, 32'hFFFF_FFFF, 0);

        start_op("DIVU", F_DIVU, 32'hFFFF_FFF9, 32'd2);
        issue_mf("DIVU lo", 1'b0, 32'h7FFF_FFFC, 33);
        issue_mf("DIVU hi", 1'b1, 32'h0000_0001, 0);

        start_op("DIV ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        issue_mf("DIV ovf lo", 1'b0, 32'h8000_0000, 33);
        issue_mf("DIV ovf hi", 1'b1, 32'h0000_0000, 0);

        start_op("DIV /0", F_DIV, 32'd5, 32'd0);
        issue_mf("DIV /0 hi", 1'b1, 32'h0000_0005, 1);
        issue_mf("DIV /0 lo", 1'b0, 32'hFFFF_FFFF, 0);

        start_op("DIVU /0", F_DIVU, 32'h0000_0099, 32'd0);
        wait_idle("DIVU /0", 1);
        issue_mf("DIVU /0 hi", 1'b1, 32'h0000_0099, 0);
        issue_mf("DIVU /0 lo", 1'b0, 32'hFFFF_FFFF, 0);

        start_op("MULT 3x4", F_MULT, 32'd3, 32'd4);
        issue_hold("MTHI busy", rtype(F_MTHI), 32'h0000_1234, 32'd0, 33);
        issue_mf("MTHI hi", 1'b1, 32'h0000_1234, 0);
        issue_mf("MULT 3x4 lo", 1'b0, 32'h0000_000C, 0);

        start_op("MULT 2x3", F_MULT, 32'd2, 32'd3);
        issue_hold("MULT b2b", rtype(F_MULT), 32'd5, 32'd6, 33);
        issue_mf("MULT b2b lo", 1'b0, 32'h0000_001E, 33);
        issue_mf("MULT b2b hi", 1'b1, 32'h0000_0000, 0);

        issue_hold("MTLO idle", rtype(F_MTLO), 32'h0000_ABCD, 32'd0, 0);
        issue_mf("MTLO lo", 1'b0, 32'h0000_ABCD, 0);

        cyc();
        instr = {6'h08, 20'd0, F_MULT}; rs_data = 32'd7; rt_data = 32'd7;
        @(negedge clk);
        check("non-rtype pipe", {29'd0, pipe_ctrl}, {29'd0, PIPE_FREE});
        cyc();
        instr = NOP;
        @(negedge clk);
        check("non-rtype busy", {31'd0, busy}, 32'd0);
        $display("non-rtype funct 0x18 ignored busy=%0d", busy);
        issue_mf("non-rtype lo", 1'b0, 32'h0000_ABCD, 0);

        start_op("MULTU rst", F_MULTU, 32'hFFFF_FFFF, 32'd2);
        repeat (9) begin
            cyc();
            instr = NOP;
        end
        cyc();
        instr = rtype(F_MFHI);
        #1;
        check("pre-rst pipe", {29'd0, pipe_ctrl}, {29'd0, PIPE_STALL});
        rst = 1'b0;
        #1;
        check("mid-rst busy", {31'd0, busy}, 32'd0);
        check("mid-rst pipe", {29'd0, pipe_ctrl}, {29'd0, PIPE_FREE});
        check("mid-rst rvalid", {31'd0, hilo_rvalid}, 32'd0);
        check("mid-rst rdata", hilo_rdata, 32'd0);
        $display("async reset at cycle 10 busy=%0d pipe=%b", busy, pipe_ctrl);
        @(posedge clk);
        #1;
        rst = 1'b1;
        instr = NOP;
        issue_mf("post-rst hi", 1'b1, 32'h0000_0000, 0);
        issue_mf("post-rst lo", 1'b0, 32'h0000_0000, 0);

        check("scoreboard drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
